regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file and shares it between two writeback requesters: the single-cycle ALU path and the long-latency load/store unit (LSU).
- Keeps a busy scoreboard of destination registers with an outstanding LSU writeback.
- Gives the issue stage a combinational stall for RAW/WAW hazards against those registers.
- Sits between execute/memory writeback and the register file; its rf_* outputs drive the register file write port directly.

Parameters:
DATA_W, 32, writeback data width
ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W
STARVE_LIMIT, 4, consecutive ALU losses before ALU is forced to win one arbitration

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
lsu_valid  in  1  LSU writeback request
lsu_ready  out  1  LSU request accepted this cycle
lsu_rd  in  ADDR_W  LSU destination register
lsu_data  in  DATA_W  load data
issue_fire  in  1  instruction issues this cycle
issue_long  in  1  issuing instruction writes back via LSU
issue_rs1  in  ADDR_W  source 1 of instruction at issue
issue_rs2  in  ADDR_W  source 2 of instruction at issue
issue_rd  in  ADDR_W  destination of instruction at issue
issue_stall  out  1  hazard: issue must not fire
rf_wEn  out  1  register file write enable (registered)
rf_write_sel  out  ADDR_W  register file write index (registered)
rf_write_data  out  DATA_W  register file write data (registered)
busy_vec  out  NUM_REGS  scoreboard, bit i = LSU write to xi pending

Behaviour:
- Reset (async, any time): rf_wEn=0, rf_write_sel=0, rf_write_data=0, busy_vec=0, starvation counter=0, internal src flag=0. A pending registered write is dropped.
- Handshake: transfer occurs when valid&&ready. At most one of alu_ready/lsu_ready is high per cycle. Ready is combinational from valid and the arbitration state only. It never depends on data or rd.
- Arbitration:
  - LSU wins by default when both are valid.
  - The starvation counter increments each cycle alu_valid&&lsu_valid and LSU wins. It saturates at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT and both are valid, ALU wins and the counter clears.
  - The counter clears on any ALU transfer and on any cycle alu_valid=0.
  - If only one requester is valid, it gets ready=1.
- Latency: exactly 1 cycle. On the edge ending a transfer cycle, rf_wEn<=1, rf_write_sel<=rd, rf_write_data<=data, src flag<=(winner==LSU). With no transfer, rf_wEn<=0 and sel/data hold.
- x0: a transfer with rd=0 completes its handshake, but rf_wEn<=0. x0 is never marked busy.
- Scoreboard set: issue_fire&&issue_long&&issue_rd!=0 sets busy[issue_rd] at the edge.
- Scoreboard clear: busy[rf_write_sel] clears on the edge where rf_wEn=1 and src flag=1. This is the same edge the register file commits, so the next cycle reads fresh data.
- Simultaneous set and clear of the same index: set wins.
- An ALU write does not alter busy_vec.
- issue_stall = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd], purely combinational. It is independent of issue_fire and has no bypass from the in-flight rf_* write.
- issue_fire while issue_stall=1 is a protocol violation; the bench asserts it never occurs. The block still applies the set.
- ALU transfer to an rd whose busy bit is set is a protocol violation; the bench flags it. The block performs the write anyway.

Test Plan:
- Reset mid-write: ALU transfer rd=5 data=0x11, assert reset in the next cycle before the edge -> rf_wEn=0 immediately, busy_vec=0, no write to x5.
- Single ALU: alu_valid, rd=3, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_wEn=1, sel=3, data=0xDEADBEEF; cycle after rf_wEn=0.
- Contention and starvation, STARVE_LIMIT=4: both valid continuously -> LSU wins 4 cycles, ALU wins the 5th, LSU wins the next 4, and so on; exactly one ready per cycle.
- Scoreboard: issue_fire, issue_long=1, rd=7 -> busy_vec[7]=1, issue_stall=1 for rs1=7. LSU writeback rd=7 -> busy[7] drops on the edge where rf_wEn=1, and issue_stall=0 the following cycle.
- Set/clear collision: LSU write to x9 committing (rf_wEn=1, src=LSU) on the same edge as issue_fire long rd=9 -> busy[9] stays 1.
- x0 handling: LSU transfer rd=0, and issue long rd=0 -> lsu_ready=1, rf_wEn stays 0, busy_vec[0] always 0, issue_stall=0 for rs1=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and LSU writebacks
module regfile_wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4,
   parameter int NUM_REGS     = 2**ADDR_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                alu_valid,
   output logic                alu_ready,
   input  logic [ADDR_W-1:0]   alu_rd,
   input  logic [DATA_W-1:0]   alu_data,
   input  logic                lsu_valid,
   output logic                lsu_ready,
   input  logic [ADDR_W-1:0]   lsu_rd,
   input  logic [DATA_W-1:0]   lsu_data,
   input  logic                issue_fire,
   input  logic                issue_long,
   input  logic [ADDR_W-1:0]   issue_rs1,
   input  logic [ADDR_W-1:0]   issue_rs2,
   input  logic [ADDR_W-1:0]   issue_rd,
   output logic                issue_stall,
   output logic                rf_wEn,
   output logic [ADDR_W-1:0]   rf_write_sel,
   output logic [DATA_W-1:0]   rf_write_data,
   output logic [NUM_REGS-1:0] busy_vec
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wen_q, wen_d;
   logic [ADDR_W-1:0]   sel_q, sel_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                src_q, src_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                alu_win, xfer;
   logic [ADDR_W-1:0]   win_rd;
   logic [NUM_REGS-1:0] set_mask, clr_mask;

   always_comb begin
      alu_win  = alu_valid && (!lsu_valid || cnt_q == LIMIT);
      xfer     = alu_win || lsu_valid;
      win_rd   = alu_win ? alu_rd : lsu_rd;
      cnt_d    = (!alu_valid || alu_win) ? '0 : (cnt_q == LIMIT ? cnt_q : cnt_q + CNT_W'(1));
      wen_d    = xfer && win_rd != '0;
      sel_d    = xfer ? win_rd : sel_q;
      data_d   = xfer ? (alu_win ? alu_data : lsu_data) : data_q;
      src_d    = xfer ? !alu_win : src_q;
      // a committing LSU write frees its register on the same edge the file is written
      clr_mask = (wen_q && src_q) ? NUM_REGS'(1) << sel_q : '0;
      set_mask = (issue_fire && issue_long && issue_rd != '0) ? NUM_REGS'(1) << issue_rd : '0;
      busy_d   = (busy_q & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         wen_q  <= 1'b0;
         sel_q  <= '0;
         data_q <= '0;
         src_q  <= 1'b0;
         busy_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         wen_q  <= wen_d;
         sel_q  <= sel_d;
         data_q <= data_d;
         src_q  <= src_d;
         busy_q <= busy_d;
      end
   end

   assign alu_ready     = alu_win;
   assign lsu_ready     = lsu_valid && !alu_win;
   assign issue_stall   = busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd];
   assign rf_wEn        = wen_q;
   assign rf_write_sel  = sel_q;
   assign rf_write_data = data_q;
   assign busy_vec      = busy_q;
endmodule
